// File: rtl/vec_prefix_sub_pipe.sv
// Two-stage pipelined SIMD subtractor (diff = a - b) built on a Kogge-Stone
// prefix network over a + ~b + 1. The carry chain is cut at lane boundaries
// chosen per beat by mode (8/16/32-bit lanes). Prefix spans 1,2,4 are
// resolved in stage 1; spans 8,16, the sum and the per-lane flags in stage 2.
module vec_prefix_sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   diff,
    output logic [WIDTH/8-1:0] borrow,
    output logic [WIDTH/8-1:0] ovf,
    output logic [WIDTH/8-1:0] zero
);
    localparam int NB = WIDTH / 8;

    // Lane width in bits for a mode code; 11 aliases the 32-bit lane.
    function automatic int f_lane(input logic [1:0] m);
        return (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    endfunction

    // A span of distance d ending at bit i stays inside its lane.
    function automatic logic f_link(input logic [1:0] m, input int i, input int d);
        return (i % f_lane(m)) >= d;
    endfunction

    // Bit i is the least significant bit of its lane.
    function automatic logic f_lsb(input logic [1:0] m, input int i);
        return (i % f_lane(m)) == 0;
    endfunction

    // Byte k is the most significant byte of its lane.
    function automatic logic f_top(input logic [1:0] m, input int k);
        return ((k * 8 + 8) % f_lane(m)) == 0;
    endfunction

    // Handshake
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_load;
    logic w_s1_load;

    assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_s1_load = in_valid & in_ready;
    assign out_valid = r_out_valid;

    // ---------------- Stage 1: operand prep and prefix spans 1,2,4 --------
    logic [WIDTH-1:0]      w_nb;
    logic [WIDTH-1:0]      w_pbit;
    logic [3:0][WIDTH-1:0] w_s1_g;
    logic [3:0][WIDTH-1:0] w_s1_p;

    assign w_nb   = ~b;
    assign w_pbit = a ^ w_nb;
    assign w_s1_p[0] = w_pbit;

    // The lane carry-in of 1 is folded into the generate at each lane LSB,
    // so G at bit i is directly the carry out of bit i.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_s1_init
        assign w_s1_g[0][gi] = (a[gi] & w_nb[gi]) | (f_lsb(mode, gi) & w_pbit[gi]);
    end

    for (genvar gl = 1; gl <= 3; gl++) begin : g_s1_lvl
        localparam int D = 1 << (gl - 1);
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi >= D) begin : g_cell
                logic w_lk;
                assign w_lk = f_link(mode, gi, D);
                assign w_s1_g[gl][gi] = w_s1_g[gl-1][gi]
                                      | (w_lk & w_s1_p[gl-1][gi] & w_s1_g[gl-1][gi-D]);
                assign w_s1_p[gl][gi] = w_lk ? (w_s1_p[gl-1][gi] & w_s1_p[gl-1][gi-D])
                                             : w_s1_p[gl-1][gi];
            end else begin : g_pass
                assign w_s1_g[gl][gi] = w_s1_g[gl-1][gi];
                assign w_s1_p[gl][gi] = w_s1_p[gl-1][gi];
            end
        end
    end

    logic [WIDTH-1:0] r1_g;
    logic [WIDTH-1:0] r1_p;
    logic [WIDTH-1:0] r1_pbit;
    logic [NB-1:0]    r1_amsb;
    logic [NB-1:0]    r1_bmsb;
    logic [1:0]       r1_mode;

    // Capture the partial prefix and the per-byte sign bits of the operands.
    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r1_g    <= w_s1_g[3];
            r1_p    <= w_s1_p[3];
            r1_pbit <= w_pbit;
            r1_mode <= mode;
            for (int k = 0; k < NB; k++) begin
                r1_amsb[k] <= a[8*k+7];
                r1_bmsb[k] <= b[8*k+7];
            end
        end
    end

    // ---------------- Stage 2: prefix spans 8,16, sum and flags -----------
    logic [2:0][WIDTH-1:0] w_s2_g;
    logic [1:0][WIDTH-1:0] w_s2_p;
    logic [WIDTH-1:0]      w_cin;
    logic [WIDTH-1:0]      w_sum;
    logic [NB-1:0]         w_z8;
    logic [NB-1:0]         w_borrow;
    logic [NB-1:0]         w_ovf;
    logic [NB-1:0]         w_zero;

    assign w_s2_g[0] = r1_g;
    assign w_s2_p[0] = r1_p;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_s2_bit
        if (gi >= 8) begin : g_c8
            logic w_lk;
            assign w_lk = f_link(r1_mode, gi, 8);
            assign w_s2_g[1][gi] = w_s2_g[0][gi] | (w_lk & w_s2_p[0][gi] & w_s2_g[0][gi-8]);
            assign w_s2_p[1][gi] = w_lk ? (w_s2_p[0][gi] & w_s2_p[0][gi-8]) : w_s2_p[0][gi];
        end else begin : g_p8
            assign w_s2_g[1][gi] = w_s2_g[0][gi];
            assign w_s2_p[1][gi] = w_s2_p[0][gi];
        end
        // Last level only needs the generate term.
        if (gi >= 16) begin : g_c16
            assign w_s2_g[2][gi] = w_s2_g[1][gi]
                                 | (f_link(r1_mode, gi, 16) & w_s2_p[1][gi] & w_s2_g[1][gi-16]);
        end else begin : g_p16
            assign w_s2_g[2][gi] = w_s2_g[1][gi];
        end
        if (gi == 0) begin : g_cin0
            assign w_cin[gi] = 1'b1;
        end else begin : g_cinn
            assign w_cin[gi] = f_lsb(r1_mode, gi) | w_s2_g[2][gi-1];
        end
    end

    assign w_sum = r1_pbit ^ w_cin;

    for (genvar gi = 0; gi < NB; gi++) begin : g_flag
        localparam int M = 8 * gi + 7;
        logic w_z16;
        logic w_z32;
        logic w_top;
        assign w_z8[gi] = ~|w_sum[8*gi +: 8];
        if (gi % 2 == 1) begin : g_z16
            assign w_z16 = w_z8[gi] & w_z8[gi-1];
        end else begin : g_nz16
            assign w_z16 = 1'b0;
        end
        if (gi % 4 == 3) begin : g_z32
            assign w_z32 = &w_z8[gi-3 +: 4];
        end else begin : g_nz32
            assign w_z32 = 1'b0;
        end
        assign w_top        = f_top(r1_mode, gi);
        assign w_borrow[gi] = w_top & ~w_s2_g[2][M];
        assign w_ovf[gi]    = w_top & (r1_amsb[gi] ^ r1_bmsb[gi]) & (r1_amsb[gi] ^ w_sum[M]);
        assign w_zero[gi]   = w_top & ((r1_mode == 2'b00) ? w_z8[gi] :
                                       (r1_mode == 2'b01) ? w_z16 : w_z32);
    end

    logic [WIDTH-1:0] r_diff;
    logic [NB-1:0]    r_borrow;
    logic [NB-1:0]    r_ovf;
    logic [NB-1:0]    r_zero;

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

    // Pipeline occupancy and the registered result; reset drops in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= '0;
            r_ovf       <= '0;
            r_zero      <= '0;
        end else begin
            if (w_s1_load)      r_s1_valid <= 1'b1;
            else if (w_s2_load) r_s1_valid <= 1'b0;

            if (w_s2_load)      r_out_valid <= 1'b1;
            else if (out_ready) r_out_valid <= 1'b0;

            if (w_s2_load) begin
                r_diff   <= w_sum;
                r_borrow <= w_borrow;
                r_ovf    <= w_ovf;
                r_zero   <= w_zero;
            end
        end
    end
endmodule

// File: tb/tb_vec_prefix_sub_pipe.sv
// Scoreboard bench for vec_prefix_sub_pipe: accepted beats push a lane-wise
// arithmetic reference result; a monitor pops and compares each delivered beat.
module tb_vec_prefix_sub_pipe;
    localparam int W  = 32;
    localparam int NB = W / 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic [NB-1:0] borrow;
    logic [NB-1:0] ovf;
    logic [NB-1:0] zero;

    vec_prefix_sub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [NB-1:0] br;
        logic [NB-1:0] ov;
        logic [NB-1:0] zr;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_mode = 1;
    bit   rand_rdy = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference: treat each lane as an unsigned / signed integer and subtract.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [1:0] mm);
        exp_t e;
        int L;
        longint unsigned msk, av, bv, dv;
        longint sa, sb_, sd, half;
        e.d = '0; e.br = '0; e.ov = '0; e.zr = '0; e.acc_cyc = 0; e.chk_lat = 0;
        L = (mm == 2'd0) ? 8 : (mm == 2'd1) ? 16 : 32;
        msk  = (64'd1 << L) - 64'd1;
        half = longint'(64'd1 << (L - 1));
        for (int lo = 0; lo < W; lo += L) begin
            int top;
            av  = (longint'(ma) >> lo) & msk;
            bv  = (longint'(mb) >> lo) & msk;
            dv  = (av - bv) & msk;
            sa  = (av >= longint'(half)) ? longint'(av) - 2 * half : longint'(av);
            sb_ = (bv >= longint'(half)) ? longint'(bv) - 2 * half : longint'(bv);
            sd  = sa - sb_;
            top = (lo + L) / 8 - 1;
            e.d      = e.d | W'(dv << lo);
            e.br[top] = (av < bv);
            e.ov[top] = (sd < -half) || (sd >= half);
            e.zr[top] = (dv == 0);
        end
        return e;
    endfunction

    // Recorder: a beat is accepted at the coming edge when valid and ready.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            e = model(a, b, mode);
            e.acc_cyc = cyc;
            e.chk_lat = lat_mode;
            sb.push_back(e);
        end
    end

    // Monitor: every delivered beat must match the oldest outstanding one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {32'd0, diff}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", 64'(diff), 64'(e.d));
                chk("borrow", 64'(borrow), 64'(e.br));
                chk("ovf", 64'(ovf), 64'(e.ov));
                chk("zero", 64'(zero), 64'(e.zr));
                if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
                $display("beat diff=%h borrow=%b ovf=%b zero=%b", diff, borrow, ovf, zero);
            end
        end
    end

    // Random back-pressure while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [1:0] tm, input bit must_ready);
        int w;
        in_valid = 1'b1; a = ta; b = tb_v; mode = tm; w = 0;
        @(negedge clk);
        if (must_ready) chk("in_ready_b2b", 64'(in_ready), 64'd1);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_flags", 64'({borrow, ovf, zero}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed lane cases, full-speed with latency checking.
        send(32'h0000_0005, 32'h0000_0003, 2'b10, 1'b1);
        send(32'h0010_FF80, 32'h0120_0181, 2'b00, 1'b1);
        send(32'h8000_1234, 32'h0001_1234, 2'b01, 1'b1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 2'b10, 1'b1);
        send(32'h8080_8080, 32'h7F7F_7F7F, 2'b00, 1'b1);
        wait_empty();

        // Back-to-back random beats, in_ready must never drop.
        for (int i = 0; i < 8; i++)
            send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
        wait_empty();

        // Fill the pipe with the sink stalled.
        lat_mode = 0;
        out_ready = 1'b0;
        send($urandom, $urandom, 2'b01, 1'b0);
        send($urandom, $urandom, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_diff_hold", 64'(diff), 64'(sb[0].d));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send($urandom, $urandom, 2'b10, 1'b0);
        wait_empty();

        // Random traffic under random back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 24; i++)
            send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_empty();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send($urandom, $urandom, 2'b00, 1'b0);
        send($urandom, $urandom, 2'b10, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        lat_mode = 1;
        send(32'h1234_5678, 32'h1234_5679, 2'b10, 1'b1);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
